aes_dec_iter: RTL

//  Iterative AES-128 decryption core, the inverse of the encryption datapath.

---
 rtl/aes_pkg.sv | 106 ++++++++++
 rtl/aes_dec_round.sv | 54 +++++
 rtl/aes_dec_iter.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 arithmetic shared by the encryptor and decryptor.
// Contents: decryptor FSM state type, GF(2^8) helpers (xtime, gmul, gf_inv),
// S-box / inverse S-box, RCON, word helpers (rot_word, sub_word) and the
// one-round key-schedule steps fwd_step (RK_i -> RK_i+1) and inv_step
// (RK_i -> RK_i-1). Byte 0 of any 128-bit value is bits [127:120].
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEYX  = 2'd1,
    ST_INIT  = 2'd2,
    ST_ROUND = 2'd3
  } dec_state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box entries are generated from the field inverse plus the affine map,
  // so the forward and inverse tables can never disagree.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo fwd_step: recover w3..w1 first, then w0 needs the old w3 (= new n3).
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// aes_dec_round: one combinational inverse round.
// Ports: state (128, current state), rk (128, round key for this round),
//        last (1, final round: skip InvMixColumns), next_state (128).
// Order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
module aes_dec_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] sub_s;
  logic [127:0] mix_s;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Row r moves right by r columns: out[r][c] = in[r][c-r]; then S^-1 and key.
  always_comb begin
    sub_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_s[127 - 8*(4*c + r) -: 8] =
          inv_sbox(state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]) ^ rk[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  // Column mixing, one 32-bit column at a time.
  always_comb begin
    mix_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      mix_s[127 - 32*c -: 32] = inv_mix_col(sub_s[127 - 32*c -: 32]);
    end
  end

  // Final round bypasses the column mix.
  always_comb begin
    if (last) next_state = sub_s;
    else      next_state = mix_s;
  end

endmodule

// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 decryptor, one inverse round per clock.
// Ports: clk, rst_n (synchronous, active low), start (accepted only when idle),
//        key_in / cipher_in (128, captured on accept), busy (cycle after
//        accept until done), done (one-cycle pulse), plain_out (128, holds
//        until the next done).
// KEY_IS_LAST=0: key_in is RK0 and is expanded forward to RK10 first.
// KEY_IS_LAST=1: key_in is already RK10.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter bit KEY_IS_LAST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] cipher_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] plain_out
);

  localparam dec_state_e AFTER_LOAD = KEY_IS_LAST ? ST_INIT : ST_KEYX;

  dec_state_e   state_r, state_s;
  logic [127:0] rk_r, ct_r, st_r, plain_r;
  logic [3:0]   kcnt_r, rnd_r;
  logic         busy_r, done_r;
  logic [127:0] round_s;

  aes_dec_round u_round (
    .state      (st_r),
    .rk         (rk_r),
    .last       (rnd_r == 4'd0),
    .next_state (round_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = AFTER_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_KEYX: begin
        if (kcnt_r == LAST_ROUND) state_s = ST_INIT;
        else                      state_s = ST_KEYX;
      end
      ST_INIT:  state_s = ST_ROUND;
      ST_ROUND: begin
        if (rnd_r == 4'd0) state_s = ST_IDLE;
        else               state_s = ST_ROUND;
      end
      default:  state_s = ST_IDLE;
    endcase
  end

  // Datapath: key expansion, round key roll-back, state update, outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_r    <= 128'h0;
      ct_r    <= 128'h0;
      st_r    <= 128'h0;
      plain_r <= 128'h0;
      kcnt_r  <= 4'd0;
      rnd_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rk_r   <= key_in;
            ct_r   <= cipher_in;
            busy_r <= 1'b1;
            kcnt_r <= 4'd1;
          end
        end
        ST_KEYX: begin
          rk_r   <= fwd_step(rk_r, rcon(kcnt_r));
          kcnt_r <= kcnt_r + 4'd1;
        end
        ST_INIT: begin
          st_r  <= ct_r ^ rk_r;
          rk_r  <= inv_step(rk_r, rcon(LAST_ROUND));
          rnd_r <= 4'd9;
        end
        ST_ROUND: begin
          st_r <= round_s;
          // RK_r -> RK_r-1 uses the RCON of round r.
          rk_r <= inv_step(rk_r, rcon(rnd_r));
          if (rnd_r == 4'd0) begin
            plain_r <= round_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            rnd_r <= rnd_r - 4'd1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign plain_out = plain_r;

endmodule
